// File: rtl/bop_delay_queue.sv
// Timed circular delay queue for the best-offset prefetcher: each pushed tag
// becomes poppable DELAY cycles after its push, approximating line fill time.
module bop_delay_queue #(
  parameter int TAG_WIDTH = 12,
  parameter int DEPTH     = 15,
  parameter int DELAY     = 60,
  parameter int TIME_BITS = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cq_enq,
  input  logic [TAG_WIDTH-1:0]         cq_in,
  input  logic                         cq_deq,
  output logic                         cq_empty,
  output logic                         cq_full,
  output logic                         cq_ready,
  output logic [TAG_WIDTH-1:0]         cq_out,
  output logic [$clog2(DEPTH+1)-1:0]   cq_count,
  output logic                         cq_drop
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [TIME_BITS-1:0] DELAY_T  = TIME_BITS'(DELAY);
  localparam logic [PW-1:0]        LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0]        FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0]     r_valid;
  logic [DEPTH-1:0]     r_mat;
  logic [TAG_WIDTH-1:0] r_tag [DEPTH];
  logic [TIME_BITS-1:0] r_ts  [DEPTH];
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;
  logic [TIME_BITS-1:0] r_now;
  logic                 r_drop;

  logic [TIME_BITS-1:0] w_elapsed [DEPTH];
  logic [DEPTH-1:0]     w_due;
  logic                 w_ready;
  logic                 w_pop;
  logic                 w_overflow;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Modular subtraction keeps elapsed correct across timer wrap.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_elapsed[i] = r_now - r_ts[i];
      w_due[i]     = (w_elapsed[i] >= DELAY_T);
    end
  end

  assign w_ready    = r_valid[r_head] & (r_mat[r_head] | w_due[r_head]);
  assign w_pop      = cq_deq & w_ready;
  assign w_overflow = cq_enq & cq_full & ~w_pop;

  assign cq_empty = (r_count == '0);
  assign cq_full  = (r_count == FULL_CNT);
  assign cq_ready = w_ready;
  assign cq_out   = cq_empty ? '0 : r_tag[r_head];
  assign cq_count = r_count;
  assign cq_drop  = r_drop;

  // Head removal is applied before the tail write so a full queue with
  // head == tail ends up holding the newly pushed entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_mat   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_now   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_now  <= r_now + TIME_BITS'(1);
      r_drop <= w_overflow;
      r_mat  <= r_mat | (r_valid & w_due);

      if (w_pop | w_overflow) begin
        r_valid[r_head] <= 1'b0;
        r_mat[r_head]   <= 1'b0;
        r_head          <= nextPtr(r_head);
      end

      if (cq_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_mat[r_tail]   <= 1'b0;
        r_tag[r_tail]   <= cq_in;
        r_ts[r_tail]    <= r_now;
        r_tail          <= nextPtr(r_tail);
      end

      case ({cq_enq, w_pop | w_overflow})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_bop_delay_queue.sv
// Randomized and directed bench for bop_delay_queue against a queue-based
// model that measures maturity in absolute (unwrapped) cycles.
module tb_bop_delay_queue;

  localparam int TAG_WIDTH = 12;
  localparam int DEPTH     = 15;
  localparam int DELAY     = 60;
  localparam int TIME_BITS = 12;
  localparam int CW        = $clog2(DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cq_enq = 1'b0;
  logic [TAG_WIDTH-1:0] cq_in = '0;
  logic                 cq_deq = 1'b0;
  logic                 cq_empty;
  logic                 cq_full;
  logic                 cq_ready;
  logic [TAG_WIDTH-1:0] cq_out;
  logic [CW-1:0]        cq_count;
  logic                 cq_drop;

  int vectors = 0;
  int errors  = 0;

  logic [TAG_WIDTH-1:0] mTag  [$];
  int                   mTime [$];
  int                   mCycle = 0;
  logic                 mDrop  = 1'b0;

  bop_delay_queue #(
    .TAG_WIDTH(TAG_WIDTH),
    .DEPTH(DEPTH),
    .DELAY(DELAY),
    .TIME_BITS(TIME_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cq_enq(cq_enq),
    .cq_in(cq_in),
    .cq_deq(cq_deq),
    .cq_empty(cq_empty),
    .cq_full(cq_full),
    .cq_ready(cq_ready),
    .cq_out(cq_out),
    .cq_count(cq_count),
    .cq_drop(cq_drop)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, mCycle);
    end
  endtask

  function automatic logic modelReady();
    return (mTag.size() > 0) && ((mCycle - mTime[0]) >= DELAY);
  endfunction

  task automatic checkState();
    checkOutput("empty", 32'(cq_empty), 32'(mTag.size() == 0));
    checkOutput("full",  32'(cq_full),  32'(mTag.size() == DEPTH));
    checkOutput("count", 32'(cq_count), 32'(mTag.size()));
    checkOutput("ready", 32'(cq_ready), 32'(modelReady()));
    checkOutput("out",   32'(cq_out),   (mTag.size() > 0) ? 32'(mTag[0]) : 32'd0);
    checkOutput("drop",  32'(cq_drop),  32'(mDrop));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_empty"}, 32'(cq_empty), 32'd1);
    checkOutput({tag, "_full"},  32'(cq_full),  32'd0);
    checkOutput({tag, "_ready"}, 32'(cq_ready), 32'd0);
    checkOutput({tag, "_out"},   32'(cq_out),   32'd0);
    checkOutput({tag, "_count"}, 32'(cq_count), 32'd0);
    checkOutput({tag, "_drop"},  32'(cq_drop),  32'd0);
  endtask

  // One clock cycle: drive inputs, check current outputs, then advance the model.
  task automatic applyStimulus(input logic enq, input logic [TAG_WIDTH-1:0] tag, input logic deq);
    logic pop;
    cq_enq = enq;
    cq_in  = tag;
    cq_deq = deq;
    checkState();
    pop = deq && modelReady();
    @(posedge clk);
    if (pop) begin
      void'(mTag.pop_front());
      void'(mTime.pop_front());
    end
    mDrop = 1'b0;
    if (enq) begin
      if (mTag.size() == DEPTH) begin
        void'(mTag.pop_front());
        void'(mTime.pop_front());
        mDrop = 1'b1;
      end
      mTag.push_back(tag);
      mTime.push_back(mCycle);
    end
    mCycle++;
    #1;
  endtask

  task automatic doReset(input int cycles);
    rst    = 1'b1;
    cq_enq = 1'b1;
    cq_deq = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      cq_in = TAG_WIDTH'($urandom);
      @(posedge clk);
      #1;
      checkResetValues("reset");
    end
    rst    = 1'b0;
    cq_enq = 1'b0;
    mTag.delete();
    mTime.delete();
    mCycle = 0;
    mDrop  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && mTag.size() > 0; i++)
      applyStimulus(1'b0, '0, 1'b1);
    checkOutput("drained", 32'(cq_empty), 32'd1);
  endtask

  initial begin
    int lat;

    doReset(3);

    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 12'h0A5, 1'b1);
    lat = 1;
    while (!cq_ready && lat < 200) begin
      applyStimulus(1'b0, '0, 1'b1);
      lat++;
    end
    checkOutput("basicLatency", 32'(lat), 32'(DELAY));
    checkOutput("basicOut", 32'(cq_out), 32'h0A5);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("basicPopped", 32'(cq_empty), 32'd1);

    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, TAG_WIDTH'(i), 1'b0);
    checkOutput("ovfFull", 32'(cq_full), 32'd1);
    checkOutput("ovfCount", 32'(cq_count), 32'(DEPTH));
    applyStimulus(1'b1, 12'h010, 1'b0);
    checkOutput("ovfDrop", 32'(cq_drop), 32'd1);
    checkOutput("ovfCountHeld", 32'(cq_count), 32'(DEPTH));
    checkOutput("ovfHead", 32'(cq_out), 32'h002);

    for (int i = 0; i < DELAY; i++) applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 12'h011, 1'b1);
    checkOutput("fullPopNoDrop", 32'(cq_drop), 32'd0);
    checkOutput("fullPopCount", 32'(cq_count), 32'(DEPTH));
    checkOutput("fullPopHead", 32'(cq_out), 32'h003);
    drain();

    for (int i = 0; i < 1500; i++)
      applyStimulus(($urandom_range(0, 2) == 0), TAG_WIDTH'($urandom), $urandom_range(0, 1) == 1);
    drain();

    for (int i = 0; i < 5000 && (mCycle % (1 << TIME_BITS)) != 4090; i++)
      applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 12'h3C3, 1'b1);
    lat = 1;
    while (!cq_ready && lat < 200) begin
      applyStimulus(1'b0, '0, 1'b1);
      lat++;
    end
    checkOutput("wrapLatency", 32'(lat), 32'(DELAY));
    checkOutput("wrapOut", 32'(cq_out), 32'h3C3);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("wrapPopped", 32'(cq_empty), 32'd1);

    applyStimulus(1'b1, 12'h5A5, 1'b0);
    for (int i = 0; i < 5000; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("holdReady", 32'(cq_ready), 32'd1);
    doReset(1);
    applyStimulus(1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bop_delay_queue.md
# bop_delay_queue

Timed circular delay queue that acts as the responder on the best-offset prefetcher's `cq_*` interface. It stores line tags pushed by the prefetcher controller at prefetch-issue time. Each tag is held until `DELAY` cycles have elapsed since it was pushed, and only then is it presented as ready. The controller pops a ready tag into the left bank of the recent-requests table; this approximates the time at which the prefetched line would have been filled.

## Interface
- `TAG_WIDTH`, 12, width of a stored tag.
- `DEPTH`, 15, number of entries; must be ≥2.
- `DELAY`, 60, cycles from push to ready; must satisfy 1 ≤ DELAY < 2^TIME_BITS.
- `TIME_BITS`, 12, width of the free-running timestamp counter.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `cq_enq`  in  1  push `cq_in` this cycle.
- `cq_in`  in  TAG_WIDTH  tag to push.
- `cq_deq`  in  1  pop the head if `cq_ready`; ignored otherwise.
- `cq_empty`  out  1  no valid entries.
- `cq_full`  out  1  DEPTH valid entries.
- `cq_ready`  out  1  head is valid and matured.
- `cq_out`  out  TAG_WIDTH  head tag; 0 when empty.
- `cq_count`  out  $clog2(DEPTH+1)  number of valid entries.
- `cq_drop`  out  1  registered one-cycle pulse indicating that the oldest entry was discarded by an overflow push in the previous cycle.

## Operation
- **Storage:** circular array of DEPTH entries, each {valid, matured, tag, ts[TIME_BITS]}. Head and tail pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of 2.
- **Timer:** `now` is a TIME_BITS counter that increments every cycle, wraps modulo 2^TIME_BITS, and is 0 after reset.
- **Push:** the entry is written at the tail with ts=now, matured=0, valid=1.
- **Elapsed time:** elapsed = (now − ts) mod 2^TIME_BITS, computed in unsigned TIME_BITS arithmetic.
- **Maturity:**
  - Each valid entry evaluates elapsed ≥ DELAY every cycle, in parallel across all entries.
  - When the condition holds, `matured` is set at the clock edge and stays set until the entry is popped.
  - Because elapsed advances by exactly 1 per cycle, every entry passes DELAY before its counter wraps. Timer wrap therefore never un-readies an entry.
- **Ready:** `cq_ready` = head.valid & (head.matured | head elapsed ≥ DELAY), combinational from state. `cq_out` = head.tag when not empty, else 0.
- **Pop:** occurs when `cq_deq` & `cq_ready`. The head entry is invalidated and the head pointer advances.
- **Overflow:** a push when full without a same-cycle pop discards the head entry and advances the head, then writes the new tag at the tail. `cq_count` stays at DEPTH and `cq_drop` pulses in the next cycle.
- **Push and pop in the same cycle:**
  - Both take effect and the count is unchanged; no drop occurs, even when full.
  - When empty, a pop is impossible because `cq_ready`=0, so only the push occurs.
- **Reset:** all entries are invalidated, pointers and timer go to 0, and `cq_drop` goes to 0. Reset takes priority over a concurrent push or pop and discards in-flight entries.

## Timing
- Reset values: `cq_empty`=1, `cq_full`=0, `cq_ready`=0, `cq_out`=0, `cq_count`=0, `cq_drop`=0.
- A push sampled in cycle c makes the entry visible in cycle c+1 (`cq_empty`=0, count updated).
- The pushed entry becomes ready in cycle c+DELAY, when it is at the head.
- A pop sampled in cycle p takes effect at the clock edge. The next head, and `cq_ready` for it, are visible in cycle p+1.
- If the next head is already matured, it can be popped back-to-back, one per cycle.
- `cq_full`, `cq_empty` and `cq_count` are registered-state derived and have no combinational path from inputs.
- `cq_ready` and `cq_out` depend only on state and have no combinational path from `cq_enq` or `cq_deq`.
- `cq_drop` is high for exactly one cycle per overflow push, in cycle c+1.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `cq_enq`=1. Expect `cq_empty`=1, `cq_ready`=0, `cq_out`=0, `cq_count`=0 and `cq_drop`=0 throughout and in the first cycle after release.
- **Basic delay:** release reset, hold `cq_deq`=1, and push 0x0A5 in cycle 10.
  - `cq_ready` is 0 in cycles 11–69.
  - `cq_ready`=1 and `cq_out`=0x0A5 in cycle 70.
  - `cq_empty`=1 in cycle 71.
- **Overflow:** with `cq_deq`=0, push tags 0x001–0x00F on consecutive cycles. Expect `cq_full`=1 and count=15. Push 0x010: expect `cq_drop`=1 for one cycle, count=15, and `cq_out`=0x002.
- **Full with same-cycle pop:** with the queue full and the head matured, assert `cq_enq`=1 and `cq_deq`=1 together. Expect no drop, count stays 15, and the head advances by one.
- **Timer wrap:** push 0x3C3 when now=4090 with `cq_deq`=1. Expect ready exactly 60 cycles later at now=54; the pop occurs then.
- **Long hold and mid-operation reset:**
  - Push one tag and hold `cq_deq`=0 for 5000 cycles. Expect `cq_ready` to stay 1 from cycle c+60 onward, including across the timer wrap.
  - Then assert `rst` for 1 cycle. Expect the queue to be empty on the next cycle with all outputs at reset values.
